// File: rtl/burst_scheduler.sv
// Round-robin burst scheduler: picks one pending requester, holds its slot
// for the burst master and waits out the master's ready handshake
// (high -> low -> high) before granting again. Bursts that never finish
// raise a sticky timeout error.
module burst_scheduler #(
   parameter int          N_REQ    = 4,
   parameter int          SLOT_W   = 256,
   parameter int          TIMEOUT  = 1024,
   // Reset value of burst_cnt; leave at zero outside of saturation tests.
   parameter logic [15:0] CNT_INIT = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*SLOT_W-1:0]   req_slot,
   input  logic [N_REQ-1:0]          req_en,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      m_valid,
   output logic [SLOT_W-1:0]         m_slot,
   input  logic                      m_ready,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy,
   output logic [15:0]               burst_cnt,
   output logic                      err,
   input  logic                      err_clr
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int TC_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [TC_W-1:0]     tcnt;
   logic [N_REQ-1:0]    eligible;
   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [SLOT_W-1:0]   win_slot;
   logic [ID_W-1:0]     rr_next;
   logic                tmo_hit;

   assign eligible = req_valid & req_en;
   assign rr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign tmo_hit  = (tcnt == TC_W'(TIMEOUT - 1));

   // Round-robin search starting at rr_ptr for the first eligible requester.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_slot  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!win_found && eligible[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
            win_slot  = req_slot[idx*SLOT_W +: SLOT_W];
         end
      end
   end

   // Accept pulse only to the winner, only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && win_found)
         req_ready[win_id] = 1'b1;
   end

   // Scheduler FSM with registered outputs; a timeout overrides err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         m_valid   <= 1'b0;
         m_slot    <= '0;
         grant_id  <= '0;
         rr_ptr    <= '0;
         busy      <= 1'b0;
         burst_cnt <= CNT_INIT;
         err       <= 1'b0;
         tcnt      <= '0;
      end else begin
         if (err_clr)
            err <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  m_slot   <= win_slot;
                  grant_id <= win_id;
                  m_valid  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  tcnt    <= '0;
                  state   <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (tmo_hit) begin
                  err    <= 1'b1;
                  busy   <= 1'b0;
                  rr_ptr <= rr_next;
                  state  <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (!m_ready)
                     state <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (m_ready) begin
                  if (burst_cnt != 16'hFFFF)
                     burst_cnt <= burst_cnt + 16'd1;
                  busy   <= 1'b0;
                  rr_ptr <= rr_next;
                  state  <= IDLE;
               end else if (tmo_hit) begin
                  err    <= 1'b1;
                  busy   <= 1'b0;
                  rr_ptr <= rr_next;
                  state  <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_scheduler.sv
// Directed bench for burst_scheduler with a transaction-level reference
// model compared against the DUT on every falling clock edge.
module tb_burst_scheduler;

   localparam int N  = 4;
   localparam int SW = 256;
   localparam int TO = 20;
   localparam logic [15:0] SAT_INIT = 16'hFFFD;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N*SW-1:0]   req_slot = '0;
   logic [N-1:0]      req_en = '0;
   logic [N-1:0]      req_ready, req_ready_s;
   logic              m_valid, m_valid_s;
   logic [SW-1:0]     m_slot, m_slot_s;
   logic              m_ready = 1'b0;
   logic [1:0]        grant_id, grant_id_s;
   logic              busy, busy_s;
   logic [15:0]       burst_cnt, burst_cnt_s;
   logic              err, err_s;
   logic              err_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   burst_scheduler #(.N_REQ(N), .SLOT_W(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_slot(req_slot),
      .req_en(req_en), .req_ready(req_ready), .m_valid(m_valid), .m_slot(m_slot),
      .m_ready(m_ready), .grant_id(grant_id), .busy(busy), .burst_cnt(burst_cnt),
      .err(err), .err_clr(err_clr));

   // Second instance starts near the top of the counter to exercise saturation.
   burst_scheduler #(.N_REQ(N), .SLOT_W(SW), .TIMEOUT(TO), .CNT_INIT(SAT_INIT)) dut_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_slot(req_slot),
      .req_en(req_en), .req_ready(req_ready_s), .m_valid(m_valid_s), .m_slot(m_slot_s),
      .m_ready(m_ready), .grant_id(grant_id_s), .busy(busy_s), .burst_cnt(burst_cnt_s),
      .err(err_s), .err_clr(err_clr));

   // ---------------- reference model (transaction level) ----------------
   int          owner = -1;   // requester holding the master, -1 when none
   bit          handshook = 0; // master accepted the offered slot
   bit          taken = 0;     // master dropped ready after accepting
   int          waited = 0;    // cycles spent waiting for the burst to finish
   int          next_first = 0;
   int          done = 0;      // completions since reset, unsaturated
   bit          merr = 0;
   int          mgid = 0;
   logic [SW-1:0] mslot = '0;

   function automatic int pick(input logic [N-1:0] e, input int start);
      for (int k = 0; k < N; k++)
         if (e[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner = -1; handshook = 0; taken = 0; waited = 0;
         next_first = 0; done = 0; merr = 0; mgid = 0; mslot = '0;
      end else begin
         int w;
         if (err_clr) merr = 0;
         if (owner < 0) begin
            w = pick(req_valid & req_en, next_first);
            if (w >= 0) begin
               owner = w; mgid = w; mslot = req_slot[w*SW +: SW];
               handshook = 0; taken = 0;
            end
         end else if (!handshook) begin
            if (m_ready) begin handshook = 1; waited = 0; end
         end else begin
            if (taken && m_ready) begin
               done++; next_first = (owner + 1) % N; owner = -1;
            end else if (waited == TO - 1) begin
               merr = 1; next_first = (owner + 1) % N; owner = -1;
            end else begin
               waited++;
               if (!m_ready) taken = 1;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] exp_rdy;
      int w;
      exp_rdy = '0;
      w = pick(req_valid & req_en, next_first);
      if (rst_n && owner < 0 && w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", SW'(req_ready), SW'(exp_rdy));
      check("busy", SW'(busy), SW'(owner >= 0));
      check("m_valid", SW'(m_valid), SW'(owner >= 0 && !handshook));
      check("m_slot", m_slot, mslot);
      check("grant_id", SW'(grant_id), SW'(mgid));
      check("burst_cnt", SW'(burst_cnt), SW'(done > 65535 ? 65535 : done));
      check("err", SW'(err), SW'(merr));
      check("sat_cnt", SW'(burst_cnt_s),
            SW'((int'(SAT_INIT) + done) > 65535 ? 65535 : int'(SAT_INIT) + done));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_mvalid(output bit ok);
      ok = 0;
      for (int n = 0; n < 30; n++) begin
         if (m_valid) begin ok = 1; break; end
         step(1);
      end
      check("wait_m_valid", SW'(ok), SW'(1));
   endtask

   // One full burst: offer, handshake, master drops then raises ready.
   task automatic do_burst(output int gid);
      bit ok;
      wait_mvalid(ok);
      gid = grant_id;
      m_ready = 1'b1; step(1);
      m_ready = 1'b0; step(1);
      m_ready = 1'b1; step(1);
   endtask

   initial begin
      int gid, n;
      bit ok;
      logic [SW-1:0] held;
      int exp_order [5] = '{0, 1, 2, 3, 0};

      for (int i = 0; i < N; i++)
         req_slot[i*SW +: SW] = {8{32'hA5C30000 + 32'(i * 17 + 1)}};

      fork
         begin
            @(posedge clk);
            forever begin
               @(negedge clk);
               compare_all();
            end
         end
      join_none

      // Reset state
      step(3);
      check("rst_busy", SW'(busy), SW'(0));
      check("rst_cnt", SW'(burst_cnt), SW'(0));
      rst_n = 1'b1;

      // All requesters pending: strict rotation and completion count
      req_valid = 4'hF; req_en = 4'hF;
      for (int b = 0; b < 5; b++) begin
         do_burst(gid);
         check("rr_order", SW'(gid), SW'(exp_order[b]));
         if (b == 3) check("cnt_after_4", SW'(burst_cnt), SW'(4));
      end
      check("slot_of_0", m_slot, req_slot[0 +: SW]);
      check("sat_hold", SW'(burst_cnt_s), SW'(16'hFFFF));

      // Masked requester is ignored until enabled
      req_valid = 4'b0100; req_en = 4'b1011; m_ready = 1'b0;
      step(3);
      check("masked_ready", SW'(req_ready), SW'(0));
      check("masked_busy", SW'(busy), SW'(0));
      req_en = 4'hF; #1;
      check("enable_ready", SW'(req_ready), SW'(4'b0100));
      step(1);
      check("enable_mvalid", SW'(m_valid), SW'(1));
      check("enable_gid", SW'(grant_id), SW'(2));

      // Long stall in ISSUE; request lines change under the burst
      held = m_slot;
      req_valid = '0; req_en = '0;
      step(50);
      check("stall_mvalid", SW'(m_valid), SW'(1));
      check("stall_slot", m_slot, held);
      check("stall_err", SW'(err), SW'(0));

      // Timeout after handshake
      m_ready = 1'b1; step(1);
      m_ready = 1'b0;
      check("wait_mvalid_lo", SW'(m_valid), SW'(0));
      n = 0;
      while (busy && n < 200) begin step(1); n++; end
      check("timeout_cycles", SW'(n), SW'(TO));
      check("timeout_err", SW'(err), SW'(1));
      check("timeout_cnt", SW'(burst_cnt), SW'(5));
      err_clr = 1'b1; step(1); err_clr = 1'b0;
      check("err_cleared", SW'(err), SW'(0));

      // Timeout coinciding with err_clr keeps err set
      req_valid = 4'b0001; req_en = 4'hF;
      wait_mvalid(ok);
      req_valid = '0;
      m_ready = 1'b1; step(1);
      m_ready = 1'b0; err_clr = 1'b1;
      n = 0;
      while (busy && n < 200) begin step(1); n++; end
      check("tmo_beats_clr", SW'(err), SW'(1));
      err_clr = 1'b0;

      // Reset in WAIT_HI abandons the burst; pointer restarts at 0
      req_valid = 4'hF;
      wait_mvalid(ok);
      check("pre_rst_gid", SW'(grant_id), SW'(1));
      m_ready = 1'b1; step(1);
      m_ready = 1'b0; step(1);
      rst_n = 1'b0; #1;
      check("rst_mid_busy", SW'(busy), SW'(0));
      check("rst_mid_mvalid", SW'(m_valid), SW'(0));
      check("rst_mid_slot", m_slot, SW'(0));
      check("rst_mid_ready", SW'(req_ready), SW'(0));
      check("rst_mid_cnt", SW'(burst_cnt), SW'(0));
      check("rst_mid_err", SW'(err), SW'(0));
      check("rst_mid_gid", SW'(grant_id), SW'(0));
      step(2);
      rst_n = 1'b1; #1;
      check("post_rst_ready", SW'(req_ready), SW'(4'b0001));
      do_burst(gid);
      check("post_rst_gid", SW'(gid), SW'(0));
      check("post_rst_cnt", SW'(burst_cnt), SW'(1));

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_scheduler.md
BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of burst requesters (2..8).
REQ-002 SHALL have parameter SLOT_W, default 256, width of one packed burst slot.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles allowed for one burst's completion.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester burst pending.
REQ-007 SHALL have port req_slot  input  N_REQ*SLOT_W  per-requester slot, requester i at bits [i*SLOT_W +: SLOT_W].
REQ-008 SHALL have port req_en  input  N_REQ  per-requester enable mask (config).
REQ-009 SHALL have port req_ready  output  N_REQ  one-hot accept pulse to the winning requester.
REQ-010 SHALL have port m_valid  output  1  slot offered to the AXI write burst master.
REQ-011 SHALL have port m_slot  output  SLOT_W  held slot for the burst master.
REQ-012 SHALL have port m_ready  input  1  burst master ready (high = idle, accepts a slot).
REQ-013 SHALL have port grant_id  output  $clog2(N_REQ)  index of last/current winner.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port burst_cnt  output  16  count of completed bursts, saturating.
REQ-016 SHALL have port err  output  1  sticky timeout flag.
REQ-017 SHALL have port err_clr  input  1  synchronous clear of err.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_LO, WAIT_HI.
REQ-019 IDLE: eligible = req_valid & req_en; if nonzero, winner = first eligible index searching rr_ptr, rr_ptr+1, ... mod N_REQ.
REQ-020 IDLE with winner: req_ready[winner]=1 combinationally that cycle; req_slot of winner registered into m_slot; grant_id <= winner; next state ISSUE.
REQ-021 req_ready SHALL be zero in every state other than IDLE and for all non-winners; at most one bit set.
REQ-022 ISSUE: m_valid=1, m_slot stable; on m_ready=1 -> WAIT_LO; else remain in ISSUE (no timeout in ISSUE).
REQ-023 WAIT_LO: m_valid=0; on m_ready=0 -> WAIT_HI (burst master has taken the burst).
REQ-024 WAIT_HI: on m_ready=1 -> IDLE, burst complete: rr_ptr <= (grant_id+1) mod N_REQ, burst_cnt += 1 saturating at 16'hFFFF.
REQ-025 Timeout counter SHALL clear on entry to WAIT_LO and count each cycle in WAIT_LO/WAIT_HI; reaching TIMEOUT -> err<=1, IDLE, rr_ptr advanced, burst_cnt not incremented.
REQ-026 req_en and req_valid SHALL be sampled only in IDLE; changes during a burst SHALL NOT affect it.
REQ-027 err_clr SHALL clear err next cycle; a timeout in the same cycle as err_clr SHALL win (err stays 1).
REQ-028 No requester granted twice in a row while another eligible requester waits (round-robin fairness).
REQ-029 Minimum turnaround: a new grant no earlier than the cycle after WAIT_HI exits.

Reset
REQ-030 On rst_n low, immediately: state IDLE, m_valid 0, m_slot 0, req_ready 0, grant_id 0, rr_ptr 0, busy 0, burst_cnt 0, err 0, timeout counter 0.
REQ-031 Reset mid-burst SHALL abandon the burst without incrementing burst_cnt; first grant after release follows rr_ptr=0.

Verification
REQ-032 All four req_valid=1, req_en=4'hF, m_ready toggling per burst -> grants in order 0,1,2,3,0; burst_cnt=4 after four completions.
REQ-033 Only requester 2 valid, req_en[2]=0 -> no req_ready, busy stays 0; set req_en[2]=1 -> req_ready=4'b0100 that cycle, m_valid next cycle.
REQ-034 m_ready held 0 while in ISSUE for 50 cycles -> m_valid stays 1, m_slot unchanged, err stays 0.
REQ-035 After handshake m_ready held 0 for TIMEOUT cycles -> err=1, state IDLE, burst_cnt unchanged; err_clr pulse -> err=0.
REQ-036 rst_n asserted in WAIT_HI with burst_cnt=3 -> all outputs zero immediately; after release requester 0 granted first.
REQ-037 burst_cnt preloaded by 65535 completions -> further completion keeps 16'hFFFF.
